dp_ram_be_init: RTL and testbench

//  True dual-port synchronous RAM with per-byte write enables and a selectable read-during-write mode.

---
 rtl/dp_ram_be_init.sv | 129 ++++++++++++
 tb/tb_dp_ram_be_init.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/dp_ram_be_init.sv
// dp_ram_be_init: true dual-port byte-enable RAM with hardware clear, read-during-write modes and collision counter
module dp_ram_be_init #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int BYTE_W = 8,
  parameter int RDW_MODE = 0,
  parameter int OUT_REG = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           init_req,
  output logic                           init_busy,
  input  logic                           en_a,
  input  logic                           en_b,
  input  logic                           we_a,
  input  logic                           we_b,
  input  logic [DATA_WIDTH/BYTE_W-1:0]   be_a,
  input  logic [DATA_WIDTH/BYTE_W-1:0]   be_b,
  input  logic [ADDR_WIDTH-1:0]          addr_a,
  input  logic [ADDR_WIDTH-1:0]          addr_b,
  input  logic [DATA_WIDTH-1:0]          din_a,
  input  logic [DATA_WIDTH-1:0]          din_b,
  output logic [DATA_WIDTH-1:0]          dout_a,
  output logic [DATA_WIDTH-1:0]          dout_b,
  output logic                           vld_a,
  output logic                           vld_b,
  output logic                           collision,
  output logic [15:0]                    coll_cnt
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int NB = DATA_WIDTH/BYTE_W;
  typedef enum logic {CLEAR, READY} state_t;
  state_t state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic act_a, act_b, coll;
  logic [DATA_WIDTH-1:0] m_a, m_b, old_a, old_b, wr_a, wr_b, rd_a, rd_b;
  logic p_va, p_vb, src_va, src_vb;
  logic [DATA_WIDTH-1:0] p_da, p_db, src_da, src_db;
  assign init_busy = state == CLEAR;
  assign act_a = en_a & ~init_busy;
  assign act_b = en_b & ~init_busy;
  for (genvar i = 0; i < NB; i++) begin : g_lane
    assign m_a[i*BYTE_W +: BYTE_W] = {BYTE_W{act_a & we_a & be_a[i]}};
    assign m_b[i*BYTE_W +: BYTE_W] = {BYTE_W{act_b & we_b & be_b[i]}};
  end
  assign old_a = mem[addr_a];
  assign old_b = mem[addr_b];
  assign wr_b = (old_b & ~m_b) | (din_b & m_b);
  // port A merges on top of port B's word when both hit the same address, so A wins shared lanes
  assign wr_a = (((addr_a == addr_b) ? wr_b : old_a) & ~m_a) | (din_a & m_a);
  assign rd_a = (RDW_MODE != 0) ? (old_a & ~m_a) | (din_a & m_a) : old_a;
  assign rd_b = (RDW_MODE != 0) ? (old_b & ~m_b) | (din_b & m_b) : old_b;
  assign coll = act_a & act_b & (addr_a == addr_b) & ((|m_a) | (|m_b));
  assign src_va = (OUT_REG != 0) ? p_va : act_a;
  assign src_vb = (OUT_REG != 0) ? p_vb : act_b;
  assign src_da = (OUT_REG != 0) ? p_da : rd_a;
  assign src_db = (OUT_REG != 0) ? p_db : rd_b;
  // clear sequencer: walk every address once, then wait for a clear request
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    if (state == CLEAR) begin
      cnt_nxt = cnt + ADDR_WIDTH'(1);
      state_nxt = (&cnt) ? READY : CLEAR;
    end else if (init_req) begin
      state_nxt = CLEAR;
      cnt_nxt = '0;
    end
  end
  // sequencer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
    end
  end
  // memory array: clear writes while busy, otherwise B then A so A lands last on a shared word
  always_ff @(posedge clk) begin
    if (init_busy) mem[cnt] <= INIT_VALUE;
    else begin
      if (|m_b) mem[addr_b] <= wr_b;
      if (|m_a) mem[addr_a] <= wr_a;
    end
  end
  // optional extra pipeline stage for the read path
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_va <= 1'b0;
      p_vb <= 1'b0;
      p_da <= '0;
      p_db <= '0;
    end else begin
      p_va <= act_a;
      p_vb <= act_b;
      if (act_a) p_da <= rd_a;
      if (act_b) p_db <= rd_b;
    end
  end
  // output registers: data holds while no result is presented
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_a <= 1'b0;
      vld_b <= 1'b0;
      dout_a <= '0;
      dout_b <= '0;
    end else begin
      vld_a <= src_va;
      vld_b <= src_vb;
      if (src_va) dout_a <= src_da;
      if (src_vb) dout_b <= src_db;
    end
  end
  // collision flag and saturating counter; a clear request zeroes the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      collision <= 1'b0;
      coll_cnt <= '0;
    end else begin
      collision <= coll;
      if (!init_busy && init_req) coll_cnt <= '0;
      else if (coll && !(&coll_cnt)) coll_cnt <= coll_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_dp_ram_be_init.sv
// tb_dp_ram_be_init: randomized and directed checks of dp_ram_be_init against a word-level reference model
module tb_dp_ram_be_init;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int BW = 8;
  localparam int NB = DW/BW;
  localparam int DEPTH = 16;
  localparam int RDW = 1;
  localparam int OREG = 1;
  localparam int LAT = OREG + 1;
  localparam logic [DW-1:0] INIT = 32'hA5A5_0F0F;
  logic clk = 1'b0, rst_n = 1'b0, init_req = 1'b0, init_busy;
  logic en_a = 1'b0, en_b = 1'b0, we_a = 1'b0, we_b = 1'b0;
  logic [NB-1:0] be_a = '0, be_b = '0;
  logic [AW-1:0] addr_a = '0, addr_b = '0;
  logic [DW-1:0] din_a = '0, din_b = '0, dout_a, dout_b;
  logic vld_a, vld_b, collision;
  logic [15:0] coll_cnt;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  dp_ram_be_init #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_W(BW), .RDW_MODE(RDW), .OUT_REG(OREG), .INIT_VALUE(INIT)) dut (
    .clk(clk), .rst_n(rst_n), .init_req(init_req), .init_busy(init_busy),
    .en_a(en_a), .en_b(en_b), .we_a(we_a), .we_b(we_b), .be_a(be_a), .be_b(be_b),
    .addr_a(addr_a), .addr_b(addr_b), .din_a(din_a), .din_b(din_b),
    .dout_a(dout_a), .dout_b(dout_b), .vld_a(vld_a), .vld_b(vld_b),
    .collision(collision), .coll_cnt(coll_cnt)
  );
  typedef struct {bit v; logic [DW-1:0] d;} ent_t;
  logic [DW-1:0] m_mem [DEPTH];
  bit m_busy, m_coll, e_va, e_vb;
  int m_cnt, m_cc;
  logic [DW-1:0] e_da, e_db;
  ent_t qa[$], qb[$];
  task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [DW-1:0] lanes(bit w, logic [NB-1:0] be);
    logic [DW-1:0] m = '0;
    for (int i = 0; i < NB; i++) if (w && be[i]) m[i*BW +: BW] = '1;
    return m;
  endfunction
  task automatic reset_model();
    ent_t e;
    e.v = 0;
    e.d = '0;
    m_busy = 1; m_cnt = 0; m_coll = 0; m_cc = 0;
    e_va = 0; e_vb = 0; e_da = '0; e_db = '0;
    qa.delete(); qb.delete();
    for (int i = 0; i < LAT - 1; i++) begin qa.push_back(e); qb.push_back(e); end
  endtask
  task automatic model();
    ent_t ea, eb;
    logic [DW-1:0] ma, mb, oa, ob;
    ea.v = 0; ea.d = '0; eb.v = 0; eb.d = '0;
    m_coll = 0;
    if (m_busy) begin
      m_mem[m_cnt] = INIT;
      m_cnt++;
      if (m_cnt == DEPTH) m_busy = 0;
    end else begin
      ma = lanes(en_a && we_a, be_a);
      mb = lanes(en_b && we_b, be_b);
      oa = m_mem[addr_a];
      ob = m_mem[addr_b];
      m_coll = en_a && en_b && addr_a == addr_b && (ma != '0 || mb != '0);
      ea.v = en_a; ea.d = RDW != 0 ? (oa & ~ma) | (din_a & ma) : oa;
      eb.v = en_b; eb.d = RDW != 0 ? (ob & ~mb) | (din_b & mb) : ob;
      m_mem[addr_b] = (m_mem[addr_b] & ~mb) | (din_b & mb);
      m_mem[addr_a] = (m_mem[addr_a] & ~ma) | (din_a & ma);
      if (init_req) begin m_busy = 1; m_cnt = 0; m_cc = 0; end
      else if (m_coll && m_cc < 65535) m_cc++;
    end
    qa.push_back(ea); qb.push_back(eb);
    ea = qa.pop_front(); eb = qb.pop_front();
    e_va = ea.v; e_vb = eb.v;
    if (ea.v) e_da = ea.d;
    if (eb.v) e_db = eb.d;
  endtask
  task automatic step();
    @(posedge clk);
    model();
    @(negedge clk);
    chk("init_busy", DW'(init_busy), DW'(m_busy));
    chk("vld_a", DW'(vld_a), DW'(e_va));
    chk("vld_b", DW'(vld_b), DW'(e_vb));
    chk("dout_a", dout_a, e_da);
    chk("dout_b", dout_b, e_db);
    chk("collision", DW'(collision), DW'(m_coll));
    chk("coll_cnt", DW'(coll_cnt), DW'(m_cc));
    init_req = 1'b0;
  endtask
  task automatic set_a(bit e, bit w, logic [NB-1:0] b, logic [AW-1:0] a, logic [DW-1:0] d);
    en_a = e; we_a = w; be_a = b; addr_a = a; din_a = d;
  endtask
  task automatic set_b(bit e, bit w, logic [NB-1:0] b, logic [AW-1:0] a, logic [DW-1:0] d);
    en_b = e; we_b = w; be_b = b; addr_b = a; din_b = d;
  endtask
  task automatic idle();
    set_a(0, 0, '0, '0, '0);
    set_b(0, 0, '0, '0, '0);
  endtask
  task automatic chk_reset(string tag);
    chk({tag, "_busy"}, DW'(init_busy), DW'(1));
    chk({tag, "_vld"}, DW'({vld_a, vld_b}), DW'(0));
    chk({tag, "_dout"}, dout_a | dout_b, '0);
    chk({tag, "_coll"}, DW'({collision, coll_cnt}), DW'(0));
  endtask
  task automatic run_clear(string tag);
    int n = 0;
    while (init_busy && n < 40) begin step(); n++; end
    chk(tag, DW'(n), DW'(DEPTH));
  endtask
  initial begin
    reset_model();
    @(negedge clk);
    chk_reset("rst0");
    rst_n = 1'b1;
    run_clear("t1_clear_len");
    for (int i = 0; i < DEPTH; i++) begin
      set_a(1, 0, '0, AW'(i), $urandom);
      set_b(1, 1, '0, AW'(DEPTH - 1 - i), $urandom);
      step();
    end
    idle();
    repeat (LAT) step();
    chk("t1_init_a", dout_a, INIT);
    chk("t1_init_b", dout_b, INIT);
    set_a(1, 1, 4'hF, 4'd3, 32'h11223344); step();
    set_a(1, 1, 4'b0101, 4'd3, 32'hAABBCCDD); step();
    set_a(1, 0, '0, 4'd3, '0); step();
    idle();
    repeat (LAT - 1) step();
    chk("t2_data", dout_a, 32'h11BB33DD);
    chk("t2_vld", DW'(vld_a), DW'(1));
    step();
    chk("t2_vld_off", DW'(vld_a), DW'(0));
    chk("t2_hold", dout_a, 32'h11BB33DD);
    set_a(1, 1, 4'hF, 4'd5, 32'h0); step();
    set_a(1, 1, 4'hF, 4'd5, 32'hFF); step();
    idle();
    repeat (LAT - 1) step();
    chk("t3_rdw", dout_a, RDW != 0 ? 32'hFF : 32'h0);
    set_a(1, 1, 4'hF, 4'd7, 32'h1);
    set_b(1, 1, 4'hF, 4'd7, 32'h2);
    step();
    chk("t4_pulse", DW'(collision), DW'(1));
    chk("t4_cnt", DW'(coll_cnt), DW'(1));
    set_a(1, 0, '0, 4'd7, '0);
    set_b(1, 0, '0, 4'd7, '0);
    step();
    chk("t4_no_pulse", DW'(collision), DW'(0));
    idle();
    repeat (LAT - 1) step();
    chk("t4_mem_a", dout_a, 32'h1);
    chk("t4_mem_b", dout_b, 32'h1);
    for (int k = 0; k < 600; k++) begin
      set_a($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, NB'($urandom), AW'($urandom_range(0, k[0] ? 3 : 15)), $urandom);
      set_b($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, NB'($urandom), AW'($urandom_range(0, k[0] ? 3 : 15)), $urandom);
      init_req = $urandom_range(0, 99) == 0;
      step();
    end
    idle();
    repeat (DEPTH + LAT) step();
    for (int k = 0; k < 70000; k++) begin
      set_a(1, 1, 4'hF, 4'd2, $urandom);
      set_b(1, 1, NB'($urandom_range(1, 15)), 4'd2, $urandom);
      step();
    end
    chk("t5_sat", DW'(coll_cnt), DW'(16'hFFFF));
    idle();
    step();
    chk("t5_sat_hold", DW'(coll_cnt), DW'(16'hFFFF));
    init_req = 1'b1;
    step();
    chk("t5_cnt_clr", DW'(coll_cnt), DW'(0));
    chk("t5_busy", DW'(init_busy), DW'(1));
    run_clear("t5_clear_len");
    init_req = 1'b1;
    step();
    repeat (9) step();
    rst_n = 1'b0;
    #1;
    reset_model();
    chk_reset("t6_rst");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int n = 0;
      while (init_busy && n < 40) begin
        set_a(n % 2 == 0, 0, '0, AW'(n), '0);
        step();
        chk("t6_no_vld", DW'(vld_a), DW'(0));
        n++;
      end
      chk("t6_clear_len", DW'(n), DW'(DEPTH));
    end
    set_a(1, 0, '0, 4'd3, '0);
    step();
    idle();
    repeat (LAT) step();
    chk("t6_cleared", dout_a, INIT);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
